// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 stream-mode mouse packets into buttons, deltas and a clamped absolute cursor.
// Define PS2_MOUSE_INIT_EN to send 0xF4 after reset and wait for the 0xFA acknowledge before decoding packets.
module ps2_mouse_packet #(
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int GAP_CYCLES = 100000,
  parameter int ACK_CYCLES = 1000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        received_data,
  input  logic              received_data_en,
  input  logic              command_was_sent,
  input  logic              error_communication_timed_out,
  output logic [7:0]        the_command,
  output logic              send_command,
  output logic              init_done,
  output logic              packet_valid,
  output logic [2:0]        buttons,
  output logic signed [8:0] dx,
  output logic signed [8:0] dy,
  output logic [9:0]        x_pos,
  output logic [9:0]        y_pos
);

  localparam int         GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [9:0] X_CENTRE   = 10'(X_MAX >> 1);
  localparam logic [9:0] Y_CENTRE   = 10'(Y_MAX >> 1);

  typedef enum logic [2:0] {
    INIT_SEND,
    INIT_WAIT,
    BYTE0,
    BYTE1,
    BYTE2
  } state_t;

`ifdef PS2_MOUSE_INIT_EN
  localparam state_t     RESET_STATE = INIT_SEND;
  localparam int         ACK_W       = $clog2(ACK_CYCLES + 1);
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
`else
  localparam state_t     RESET_STATE = BYTE0;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [7:0]        r_b0;
  logic [7:0]        r_b1;
  logic              w_in_packet;
  logic              w_gap_timeout;
  logic              w_latch_b0;
  logic              w_latch_b1;
  logic              w_form_packet;

  logic              r_packet_valid;
  logic [2:0]        r_buttons;
  logic signed [8:0] r_dx;
  logic signed [8:0] r_dy;
  logic [9:0]        r_x_pos;
  logic [9:0]        r_y_pos;

  logic              w_overflow;
  logic signed [8:0] w_dx;
  logic signed [8:0] w_dy;
  logic [11:0]       w_x_sum;
  logic [11:0]       w_y_sum;
  logic [9:0]        w_x_new;
  logic [9:0]        w_y_new;

`ifdef PS2_MOUSE_INIT_EN
  logic [ACK_W-1:0]  r_ack_cnt;
  logic              r_send_command;
  logic              r_init_done;
  logic              w_send_next;
  logic              w_init_done_set;
  logic              w_unused_ok;
  assign w_unused_ok = ^{command_was_sent, r_b0[3]};
`else
  logic              w_unused_ok;
  assign w_unused_ok = ^{command_was_sent, error_communication_timed_out, r_b0[3]};
`endif

  assign w_in_packet   = (r_state == BYTE1) || (r_state == BYTE2);
  assign w_gap_timeout = w_in_packet && (r_gap_cnt == GAP_W'(GAP_CYCLES));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A byte that lands on the gap timeout starts a fresh packet instead of continuing the stale one.
  always_comb begin
    w_state_next  = r_state;
    w_latch_b0    = 1'b0;
    w_latch_b1    = 1'b0;
    w_form_packet = 1'b0;
`ifdef PS2_MOUSE_INIT_EN
    w_send_next     = 1'b0;
    w_init_done_set = 1'b0;
`endif
    case (r_state)
`ifdef PS2_MOUSE_INIT_EN
      INIT_SEND: begin
        w_send_next  = 1'b1;
        w_state_next = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (received_data_en) begin
          if (received_data == BYTE_ACK) begin
            w_init_done_set = 1'b1;
            w_state_next    = BYTE0;
          end else begin
            w_state_next = INIT_SEND;
          end
        end else if (error_communication_timed_out ||
                     (r_ack_cnt == ACK_W'(ACK_CYCLES - 1))) begin
          w_state_next = INIT_SEND;
        end
      end
`endif
      BYTE0: begin
        if (received_data_en && received_data[3]) begin
          w_latch_b0   = 1'b1;
          w_state_next = BYTE1;
        end
      end
      BYTE1: begin
        if (received_data_en && w_gap_timeout) begin
          w_latch_b0   = received_data[3];
          w_state_next = received_data[3] ? BYTE1 : BYTE0;
        end else if (received_data_en) begin
          w_latch_b1   = 1'b1;
          w_state_next = BYTE2;
        end else if (w_gap_timeout) begin
          w_state_next = BYTE0;
        end
      end
      BYTE2: begin
        if (received_data_en && w_gap_timeout) begin
          w_latch_b0   = received_data[3];
          w_state_next = received_data[3] ? BYTE1 : BYTE0;
        end else if (received_data_en) begin
          w_form_packet = 1'b1;
          w_state_next  = BYTE0;
        end else if (w_gap_timeout) begin
          w_state_next = BYTE0;
        end
      end
      default: begin
        w_state_next = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || !w_in_packet || received_data_en) begin
      r_gap_cnt <= '0;
    end else begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_b0 <= '0;
      r_b1 <= '0;
    end else begin
      if (w_latch_b0) r_b0 <= received_data;
      if (w_latch_b1) r_b1 <= received_data;
    end
  end

  // Overflowed packets carry meaningless deltas, so they are zeroed rather than applied.
  assign w_overflow = r_b0[6] | r_b0[7];
  assign w_dx       = w_overflow ? 9'sd0 : $signed({r_b0[4], r_b1});
  assign w_dy       = w_overflow ? 9'sd0 : $signed({r_b0[5], received_data});
  assign w_x_sum    = {2'b00, r_x_pos} + {{3{w_dx[8]}}, w_dx};
  assign w_y_sum    = {2'b00, r_y_pos} - {{3{w_dy[8]}}, w_dy};

  always_comb begin
    w_x_new = w_x_sum[9:0];
    if (w_x_sum[11]) begin
      w_x_new = '0;
    end else if (w_x_sum > 12'(X_MAX)) begin
      w_x_new = 10'(X_MAX);
    end
    w_y_new = w_y_sum[9:0];
    if (w_y_sum[11]) begin
      w_y_new = '0;
    end else if (w_y_sum > 12'(Y_MAX)) begin
      w_y_new = 10'(Y_MAX);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_packet_valid <= 1'b0;
      r_buttons      <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_x_pos        <= X_CENTRE;
      r_y_pos        <= Y_CENTRE;
    end else begin
      r_packet_valid <= w_form_packet;
      if (w_form_packet) begin
        r_buttons <= r_b0[2:0];
        r_dx      <= w_dx;
        r_dy      <= w_dy;
        r_x_pos   <= w_x_new;
        r_y_pos   <= w_y_new;
      end
    end
  end

`ifdef PS2_MOUSE_INIT_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ack_cnt      <= '0;
      r_send_command <= 1'b0;
      r_init_done    <= 1'b0;
    end else begin
      r_ack_cnt      <= (r_state == INIT_WAIT) ? r_ack_cnt + ACK_W'(1) : '0;
      r_send_command <= w_send_next;
      if (w_init_done_set) r_init_done <= 1'b1;
    end
  end

  assign send_command = r_send_command;
  assign init_done    = r_init_done;
`else
  assign send_command = 1'b0;
  assign init_done    = 1'b1;
`endif

  assign the_command  = CMD_ENABLE;
  assign packet_valid = r_packet_valid;
  assign buttons      = r_buttons;
  assign dx           = r_dx;
  assign dy           = r_dy;
  assign x_pos        = r_x_pos;
  assign y_pos        = r_y_pos;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Directed bench for ps2_mouse_packet; shortened gap/ack limits keep the run brief.
// Init-handshake scenarios are built only when PS2_MOUSE_INIT_EN is defined.
module tb_ps2_mouse_packet;

  localparam int GAP = 64;
  localparam int ACK = 200;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        received_data = 8'h00;
  logic              received_data_en = 1'b0;
  logic              command_was_sent = 1'b0;
  logic              error_communication_timed_out = 1'b0;
  logic [7:0]        the_command;
  logic              send_command;
  logic              init_done;
  logic              packet_valid;
  logic [2:0]        buttons;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic [9:0]        x_pos;
  logic [9:0]        y_pos;

  int n_checks = 0;
  int n_errors = 0;
  int pkt_cnt  = 0;
  int cmd_cnt  = 0;

  ps2_mouse_packet #(
    .X_MAX(639), .Y_MAX(479), .GAP_CYCLES(GAP), .ACK_CYCLES(ACK)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .the_command(the_command),
    .send_command(send_command),
    .init_done(init_done),
    .packet_valid(packet_valid),
    .buttons(buttons),
    .dx(dx),
    .dy(dy),
    .x_pos(x_pos),
    .y_pos(y_pos)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (packet_valid) pkt_cnt <= pkt_cnt + 1;
    if (send_command) cmd_cnt <= cmd_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
  endtask

  // Leaves the bench on the negedge where packet_valid of the third byte is visible.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    idle(1);
    send_byte(b1);
    idle(1);
    send_byte(b2);
    $display("pkt %02h %02h %02h -> valid=%0d btn=%03b dx=%0d dy=%0d x=%0d y=%0d",
             b0, b1, b2, packet_valid, buttons, dx, dy, x_pos, y_pos);
  endtask

  task automatic do_reset;
    @(negedge CLOCK_50);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
  endtask

  task automatic bring_up;
    do_reset();
`ifdef PS2_MOUSE_INIT_EN
    begin
      int i;
      for (i = 0; i < 50 && !send_command; i++) @(negedge CLOCK_50);
      if (!send_command) begin
        n_checks++; n_errors++;
        $display("FAIL bring_up_pulse: got no send_command within %0d cycles want one", i);
      end
      send_byte(8'hFA);
      idle(2);
    end
`endif
  endtask

  task automatic test_reset;
    @(negedge CLOCK_50);
    reset = 1'b1;
    idle(3);
    n_checks++; if (x_pos !== 10'd319) begin n_errors++; $display("FAIL reset_x: got %0d want 319", x_pos); end
    n_checks++; if (y_pos !== 10'd239) begin n_errors++; $display("FAIL reset_y: got %0d want 239", y_pos); end
    n_checks++; if (buttons !== 3'b000 || dx !== 9'h000 || dy !== 9'h000) begin
      n_errors++; $display("FAIL reset_pkt: got btn=%03b dx=%0d dy=%0d want 0/0/0", buttons, dx, dy);
    end
    n_checks++; if (packet_valid !== 1'b0 || send_command !== 1'b0) begin
      n_errors++; $display("FAIL reset_strobes: got valid=%0d send=%0d want 0/0", packet_valid, send_command);
    end
    n_checks++; if (the_command !== 8'hF4) begin n_errors++; $display("FAIL reset_cmd: got %02h want F4", the_command); end
`ifdef PS2_MOUSE_INIT_EN
    n_checks++; if (init_done !== 1'b0) begin n_errors++; $display("FAIL reset_init: got %0d want 0", init_done); end
`else
    n_checks++; if (init_done !== 1'b1) begin n_errors++; $display("FAIL reset_init: got %0d want 1", init_done); end
`endif
    reset = 1'b0;
  endtask

`ifdef PS2_MOUSE_INIT_EN
  task automatic test_init_ack;
    int base;
    int i;
    do_reset();
    base = cmd_cnt;
    for (i = 0; i < 50 && !send_command; i++) @(negedge CLOCK_50);
    n_checks++; if (send_command !== 1'b1 || the_command !== 8'hF4) begin
      n_errors++; $display("FAIL init_pulse: got send=%0d cmd=%02h want 1/F4", send_command, the_command);
    end
    send_byte(8'hFA);
    idle(5);
    n_checks++; if (init_done !== 1'b1) begin n_errors++; $display("FAIL init_done: got %0d want 1", init_done); end
    n_checks++; if (cmd_cnt - base !== 1) begin n_errors++; $display("FAIL init_pulses: got %0d want 1", cmd_cnt - base); end
  endtask

  task automatic test_init_retry;
    int base;
    int i;
    do_reset();
    base = cmd_cnt;
    for (i = 0; i < 50 && !send_command; i++) @(negedge CLOCK_50);
    send_byte(8'hFE);
    idle(ACK + 50);
    n_checks++; if (cmd_cnt - base !== 3) begin n_errors++; $display("FAIL retry_pulses: got %0d want 3", cmd_cnt - base); end
    n_checks++; if (init_done !== 1'b0) begin n_errors++; $display("FAIL retry_init: got %0d want 0", init_done); end
    send_byte(8'hFA);
    idle(5);
    n_checks++; if (init_done !== 1'b1) begin n_errors++; $display("FAIL retry_done: got %0d want 1", init_done); end
    n_checks++; if (cmd_cnt - base !== 3) begin n_errors++; $display("FAIL retry_final: got %0d want 3", cmd_cnt - base); end
  endtask
`else
  task automatic test_init_default;
    int base;
    do_reset();
    base = cmd_cnt;
    idle(20);
    n_checks++; if (init_done !== 1'b1) begin n_errors++; $display("FAIL noinit_done: got %0d want 1", init_done); end
    n_checks++; if (cmd_cnt - base !== 0) begin n_errors++; $display("FAIL noinit_pulses: got %0d want 0", cmd_cnt - base); end
  endtask
`endif

  task automatic test_basic_packet;
    bring_up();
    send_pkt(8'h29, 8'h10, 8'hF0);
    n_checks++; if (packet_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %0d want 1", packet_valid); end
    n_checks++; if (buttons !== 3'b001) begin n_errors++; $display("FAIL basic_btn: got %03b want 001", buttons); end
    n_checks++; if (dx !== 9'h010 || dy !== 9'h1F0) begin
      n_errors++; $display("FAIL basic_delta: got dx=%0d dy=%0d want 16/-16", dx, dy);
    end
    n_checks++; if (x_pos !== 10'd335 || y_pos !== 10'd255) begin
      n_errors++; $display("FAIL basic_pos: got x=%0d y=%0d want 335/255", x_pos, y_pos);
    end
    idle(1);
    n_checks++; if (packet_valid !== 1'b0) begin n_errors++; $display("FAIL basic_strobe: got %0d want 0", packet_valid); end
  endtask

  task automatic test_clamp_x_low;
    int exp_x;
    exp_x = 335;
    for (int k = 0; k < 3; k++) begin
      send_pkt(8'h18, 8'h80, 8'h00);
      exp_x = (exp_x - 128 < 0) ? 0 : exp_x - 128;
      n_checks++; if (x_pos !== 10'(exp_x) || dx !== 9'h180 || y_pos !== 10'd255) begin
        n_errors++; $display("FAIL xlow_%0d: got x=%0d dx=%0d y=%0d want %0d/-128/255", k, x_pos, dx, y_pos, exp_x);
      end
    end
  endtask

  task automatic test_clamp_x_high;
    int exp_x;
    bring_up();
    exp_x = 319;
    for (int k = 0; k < 6; k++) begin
      send_pkt(8'h08, 8'h7F, 8'h00);
      exp_x = (exp_x + 127 > 639) ? 639 : exp_x + 127;
      n_checks++; if (x_pos !== 10'(exp_x) || y_pos !== 10'd239) begin
        n_errors++; $display("FAIL xhigh_%0d: got x=%0d y=%0d want %0d/239", k, x_pos, y_pos, exp_x);
      end
    end
  endtask

  task automatic test_clamp_y;
    int exp_y;
    exp_y = 239;
    for (int k = 0; k < 2; k++) begin
      send_pkt(8'h28, 8'h00, 8'h80);
      exp_y = (exp_y + 128 > 479) ? 479 : exp_y + 128;
      n_checks++; if (y_pos !== 10'(exp_y) || dy !== 9'h180) begin
        n_errors++; $display("FAIL yhigh_%0d: got y=%0d dy=%0d want %0d/-128", k, y_pos, dy, exp_y);
      end
    end
    for (int k = 0; k < 4; k++) begin
      send_pkt(8'h08, 8'h00, 8'h7F);
      exp_y = (exp_y - 127 < 0) ? 0 : exp_y - 127;
      n_checks++; if (y_pos !== 10'(exp_y) || x_pos !== 10'd639) begin
        n_errors++; $display("FAIL ylow_%0d: got y=%0d x=%0d want %0d/639", k, y_pos, x_pos, exp_y);
      end
    end
  endtask

  task automatic test_resync;
    int base;
    idle(2);
    base = pkt_cnt;
    send_byte(8'h00);
    idle(2);
    send_pkt(8'h08, 8'h01, 8'h01);
    n_checks++; if (packet_valid !== 1'b1 || dx !== 9'h001 || dy !== 9'h001) begin
      n_errors++; $display("FAIL resync_pkt: got valid=%0d dx=%0d dy=%0d want 1/1/1", packet_valid, dx, dy);
    end
    idle(10);
    n_checks++; if (pkt_cnt - base !== 1) begin n_errors++; $display("FAIL resync_count: got %0d want 1", pkt_cnt - base); end
  endtask

  task automatic test_gap;
    int base;
    idle(2);
    base = pkt_cnt;
    send_byte(8'h08);
    idle(1);
    send_byte(8'h05);
    idle(GAP + 20);
    send_pkt(8'h08, 8'h02, 8'h00);
    n_checks++; if (dx !== 9'h002 || dy !== 9'h000) begin
      n_errors++; $display("FAIL gap_delta: got dx=%0d dy=%0d want 2/0", dx, dy);
    end
    idle(10);
    n_checks++; if (pkt_cnt - base !== 1) begin n_errors++; $display("FAIL gap_count: got %0d want 1", pkt_cnt - base); end
  endtask

  task automatic test_overflow;
    bring_up();
    send_pkt(8'h4B, 8'h10, 8'h10);
    n_checks++; if (packet_valid !== 1'b1 || buttons !== 3'b011) begin
      n_errors++; $display("FAIL ovf_valid: got valid=%0d btn=%03b want 1/011", packet_valid, buttons);
    end
    n_checks++; if (dx !== 9'h000 || dy !== 9'h000) begin
      n_errors++; $display("FAIL ovf_delta: got dx=%0d dy=%0d want 0/0", dx, dy);
    end
    n_checks++; if (x_pos !== 10'd319 || y_pos !== 10'd239) begin
      n_errors++; $display("FAIL ovf_pos: got x=%0d y=%0d want 319/239", x_pos, y_pos);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge CLOCK_50);
    received_data_en = 1'b1;
    received_data = 8'h09;
    @(negedge CLOCK_50);
    received_data = 8'h05;
    @(negedge CLOCK_50);
    received_data = 8'h03;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
    $display("pkt 09 05 03 (burst) -> valid=%0d btn=%03b dx=%0d dy=%0d x=%0d y=%0d",
             packet_valid, buttons, dx, dy, x_pos, y_pos);
    n_checks++; if (packet_valid !== 1'b1 || buttons !== 3'b001) begin
      n_errors++; $display("FAIL b2b_valid: got valid=%0d btn=%03b want 1/001", packet_valid, buttons);
    end
    n_checks++; if (x_pos !== 10'd324 || y_pos !== 10'd236) begin
      n_errors++; $display("FAIL b2b_pos: got x=%0d y=%0d want 324/236", x_pos, y_pos);
    end
  endtask

  initial begin
    test_reset();
`ifdef PS2_MOUSE_INIT_EN
    test_init_ack();
    test_init_retry();
`else
    test_init_default();
`endif
    test_basic_packet();
    test_clamp_x_low();
    test_clamp_x_high();
    test_clamp_y();
    test_resync();
    test_gap();
    test_overflow();
    test_back_to_back();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
